// File: rtl/bcd_ascii_tx.sv
// Serialises five BCD digits as ASCII bytes plus a terminator over valid/ready; first byte valid 1 cycle after start.
// Bytes are held until tx_ready; optional leading-zero blanking via BCD_ASCII_TX_LZB_EN.
module bcd_ascii_tx #(
  parameter logic [7:0] TERM_CHAR = 8'h0A,
  parameter logic [7:0] BAD_CHAR  = 8'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] bcd4,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;

  state_t      state;
  logic [19:0] dig_q;
  logic [19:0] dig_in;
  logic [2:0]  idx;
  logic [2:0]  first_idx;
  logic        xfer;

  assign dig_in = {bcd4, bcd3, bcd2, bcd1, bcd0};
  assign xfer   = tx_valid & tx_ready;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? BAD_CHAR : (8'h30 + {4'h0, d});
  endfunction

  function automatic logic [3:0] pick(input logic [19:0] v, input logic [2:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

`ifdef BCD_ASCII_TX_LZB_EN
  // Highest nonzero digit; invalid codes count as nonzero so they are never blanked.
  always_comb begin
    first_idx = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (dig_in[4*i +: 4] != 4'd0) first_idx = 3'(i);
    end
  end
`else
  assign first_idx = 3'd4;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      dig_q    <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dig_q    <= dig_in;
            idx      <= first_idx;
            tx_data  <= to_ascii(pick(dig_in, first_idx));
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx == 3'd0) begin
              tx_data <= TERM_CHAR;
              state   <= TERM;
            end else begin
              idx     <= idx - 3'd1;
              tx_data <= to_ascii(pick(dig_q, idx - 3'd1));
            end
          end
        end
        TERM: begin
          if (xfer) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Scoreboard bench for bcd_ascii_tx: driver pushes expected bytes, negedge monitor pops on each transfer.
module tb_bcd_ascii_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] bcd4 = '0, bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held;
  logic       held_vld = 1'b0;

  bcd_ascii_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bcd4(bcd4), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every transfer pops one expected byte; stalled bytes must stay put.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_vld = 1'b0;
    end else if (tx_valid) begin
      if (held_vld) chk("stable_while_stalled", {24'h0, tx_data}, {24'h0, held});
      if (tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          chk("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
        held_vld = 1'b0;
      end else begin
        held     = tx_data;
        held_vld = 1'b1;
      end
    end else begin
      if (held_vld) chk("valid_dropped", 32'd0, 32'd1);
      held_vld = 1'b0;
      if (tx_data !== 8'h00) chk("idle_data_zero", {24'h0, tx_data}, 32'h0);
    end
  end

  // Called #1 after a rising edge while idle (or in the done cycle).
  task automatic start_num(input logic [19:0] dig, input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    {bcd4, bcd3, bcd2, bcd1, bcd0} = dig;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("valid_after_capture", {31'h0, tx_valid}, 32'd1);
    chk("busy_after_capture", {31'h0, busy}, 32'd1);
    chk("done_low_after_capture", {31'h0, done}, 32'd0);
  endtask

  // mode 0: ready high; 1: ready toggles; 2: ready high plus a start pulse and digit change while busy.
  task automatic wait_done(input int mode, input int n);
    int  k;
    bit  seen;
    k = 0;
    seen = 0;
    while (k < 200 && !seen) begin
      tx_ready = (mode == 1) ? ((k % 2) == 0) : 1'b1;
      start    = (mode == 2 && k == 2);
      if (mode == 2 && k == 1) {bcd4, bcd3, bcd2, bcd1, bcd0} = 20'h99999;
      @(posedge clk); #1;
      k++;
      if (done) seen = 1;
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    chk("done_seen", {31'h0, seen}, 32'd1);
    if (mode != 1) chk("cycles_to_done", k, n);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_one_cycle", {31'h0, done}, 32'd0);
    chk("idle_valid", {31'h0, tx_valid}, 32'd0);
    chk("idle_busy", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_data", {24'h0, tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef BCD_ASCII_TX_LZB_EN
    start_num(20'h00307, 48'h0000_3330370A, 4); wait_done(0, 4); idle_check();
    start_num(20'h00000, 48'h0000_0000300A, 2); wait_done(0, 2); idle_check();
`else
    start_num(20'h00307, 48'h3030_3330370A, 6); wait_done(0, 6); idle_check();
    start_num(20'h00000, 48'h3030_3030300A, 6); wait_done(0, 6); idle_check();
`endif

    start_num(20'h65535, 48'h3635_3533350A, 6); wait_done(1, 6); idle_check();

    start_num(20'h11C11, 48'h3131_3F31310A, 6); wait_done(2, 6); idle_check();
    repeat (3) idle_check();

    // Reset after the second byte has gone out: no terminator may follow.
    start_num(20'h12345, 48'h3132_3334350A, 6);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", {31'h0, tx_valid}, 32'd0);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_data", {24'h0, tx_data}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'd0);
    chk("midrst_sent_two", exp_q.size(), 32'd4);
    exp_q.delete();
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    idle_check();
`ifdef BCD_ASCII_TX_LZB_EN
    start_num(20'h00042, 48'h0000_0034320A, 3); wait_done(0, 3); idle_check();
`else
    start_num(20'h00042, 48'h3030_3034320A, 6); wait_done(0, 6); idle_check();
`endif

    // Back-to-back: second start issued in the done cycle.
    start_num(20'h10000, 48'h3130_3030300A, 6); wait_done(0, 6);
    start_num(20'h99999, 48'h3939_3939390A, 6); wait_done(0, 6); idle_check();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_ascii_tx.md
BCD_ASCII_TX -- requirements
Module: bcd_ascii_tx

Interface
REQ-001 SHALL have parameter TERM_CHAR, default 8'h0A, the terminator byte sent after the last digit.
REQ-002 SHALL have parameter BAD_CHAR, default 8'h3F ('?'), the byte sent for any digit code greater than 9.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to send one number.
REQ-006 SHALL have ports bcd4, bcd3, bcd2, bcd1, bcd0, input, 4 each, the BCD digits from the binary-to-BCD stage (bcd4 most significant).
REQ-007 SHALL have port tx_data, output, 8, the ASCII byte offered downstream.
REQ-008 SHALL have port tx_valid, output, 1, meaning tx_data holds a valid byte.
REQ-009 SHALL have port tx_ready, input, 1, meaning downstream accepts a byte.
REQ-010 SHALL have port busy, output, 1, high while not in IDLE.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse when a number completes.

Function
REQ-012 SHALL implement the states IDLE, SEND and TERM.
REQ-013 SHALL, in IDLE with start=1 at an edge, capture all five digits and the first-digit index into registers and enter SEND; busy and tx_valid go high from the next cycle (1-cycle latency).
REQ-014 SHALL ignore start while busy=1; captured digits do not change until the number completes.
REQ-015 SHALL count a byte as transferred at a rising edge where tx_valid=1 and tx_ready=1.
REQ-016 SHALL hold tx_data stable and tx_valid high until the byte is transferred; tx_valid never drops without a transfer except on reset.
REQ-017 SHALL, in SEND, drive tx_data = 8'h30 + digit for digit values 0..9 and BAD_CHAR for values 10..15.
REQ-018 SHALL send digits from the start index down to index 0, moving to the next lower digit on each transfer, and enter TERM after digit 0 is transferred.
REQ-019 SHALL, in TERM, drive tx_data = TERM_CHAR; on its transfer, enter IDLE, drop tx_valid and busy, and pulse done for exactly one cycle.
REQ-020 SHALL accept start again in the cycle done is high (IDLE), allowing back-to-back numbers with no dead cycle beyond REQ-013.
REQ-021 SHALL tolerate tx_ready held high permanently: one byte per cycle, so N bytes take N cycles after the capture edge.
REQ-022 SHALL drive tx_data to 8'h00 whenever tx_valid=0.

Reset
REQ-023 SHALL, at any edge with rst_n=0, enter IDLE and set tx_valid=0, tx_data=8'h00, busy=0, done=0, and clear the digit registers, including mid-number; a partially sent number is abandoned with no terminator.
REQ-024 SHALL give rst_n priority over start and tx_ready at the same edge.

Configuration
REQ-025 SHALL support macro BCD_ASCII_TX_LZB_EN (leading-zero blanking).
REQ-026 SHALL, with BCD_ASCII_TX_LZB_EN defined, set the start index at capture to the highest index holding a nonzero digit, or 0 if all digits are zero; a nonzero invalid digit counts as nonzero.
REQ-027 SHALL, with BCD_ASCII_TX_LZB_EN undefined, always use start index 4, so every number is exactly five digits plus the terminator.

Verification
REQ-028 SHALL pass: digits 0,0,3,0,7 (bcd4..bcd0), tx_ready=1, LZB on -> bytes 33 30 37 0A on 4 consecutive cycles, then done pulse; LZB off -> 30 30 33 30 37 0A.
REQ-029 SHALL pass: all digits 0, LZB on -> bytes 30 0A only; done high exactly 1 cycle.
REQ-030 SHALL pass: digits 6,5,5,3,5, tx_ready toggled 1-0-1-0 -> 36 35 35 33 35 0A, each byte held stable through the low cycles, no byte duplicated or dropped.
REQ-031 SHALL pass: digit bcd2=4'hC, others 1 -> the third byte is 3F; start pulsed during busy -> ignored, no extra bytes.
REQ-032 SHALL pass: rst_n=0 after the second byte of a number -> next cycle tx_valid=0, busy=0, no terminator; a following start sends a full new number correctly.
REQ-033 SHALL pass: start asserted in the done cycle with new digits 9,9,9,9,9 -> the second number starts on the next cycle and sends 39 39 39 39 39 0A.
